logic_unit_arbiter: RTL and testbench

// Round-robin arbiter and sequencer that shares one registered bitwise logic unit among N requesters.

---
 rtl/logic_unit_pkg.sv | 35 +++
 rtl/logic_op_unit.sv | 51 +++++
 rtl/logic_unit_arbiter.sv | 147 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types, opcodes and the per-bit evaluator for the shared logic unit.
package logic_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Single-bit evaluation; every opcode is bitwise, so callers loop over the width.
  function automatic logic lu_eval(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_unit.sv
// Shared registered bitwise logic unit: evaluates on en_i, then shifts the result
// through LAT register stages so res_o is valid LAT cycles after capture.
module logic_op_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o
);

  logic [W-1:0]            eval;
  logic [LAT-1:0][W-1:0]   stage_q, stage_d;

  // Bitwise evaluation of the captured operands.
  always_comb begin
    eval = '0;
    for (int i = 0; i < W; i++) begin
      eval[i] = lu_eval(op_i, a_i[i], b_i[i]);
    end
  end

  // Stage 0 loads only on capture; later stages shift every cycle.
  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d[0] = eval;
    end
    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Result pipeline registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign res_o = stage_q[LAT-1];

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered logic unit among N requesters.
// One operation in flight at a time: grant in IDLE, count latency in BUSY,
// hold the result on the response port in DONE until it is accepted.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 1,
  localparam int unsigned IdW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [3*N-1:0] op,
  input  logic [W*N-1:0] in1,
  input  logic [W*N-1:0] in2,
  output logic [N-1:0]   gnt,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IdW-1:0] rsp_id,
  output logic [W-1:0]   rsp_data
);

  state_t         state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [IdW-1:0] id_q, id_d;
  logic [IdW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;

  logic           win_found;
  logic [IdW-1:0] win_idx;
  logic [IdW:0]   cand;
  logic           unit_en;
  logic [2:0]     op_sel;
  logic [W-1:0]   a_sel, b_sel;
  logic [W-1:0]   unit_res;

  // Round-robin search: first set req bit starting at ptr, wrapping past N-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IdW+1)'(k);
      if (cand >= (IdW+1)'(N)) begin
        cand = cand - (IdW+1)'(N);
      end
      if (!win_found && req[cand[IdW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdW-1:0];
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < N; i++) begin
      if (IdW'(i) == win_idx) begin
        op_sel = op[3*i +: 3];
        a_sel  = in1[W*i +: W];
        b_sel  = in2[W*i +: W];
      end
    end
  end

  logic_op_unit #(
    .W   (W),
    .LAT (LAT)
  ) u_unit (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (unit_en),
    .op_i   (op_sel),
    .a_i    (a_sel),
    .b_i    (b_sel),
    .res_o  (unit_res)
  );

  // Next-state, grant and response-valid logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    gnt        = '0;
    unit_en    = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // No grant while reset is asserted, even though the state is IDLE.
        if (win_found && rst_n) begin
          gnt     = N'(1) << win_idx;
          unit_en = 1'b1;
          id_d    = win_idx;
          cnt_d   = 3'(LAT);
          ptr_d   = (win_idx == IdW'(N-1)) ? '0 : win_idx + 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rsp_data_d = unit_res;
          rsp_id_d   = id_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_id   = rsp_id_q;
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench: LAT=1 instance for most scenarios, LAT=3 instance
// for the longer latency case.
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] op;
  logic [31:0] in1, in2;
  logic [3:0]  gnt;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;

  logic [3:0]  req3;
  logic [11:0] op3;
  logic [31:0] in13, in23;
  logic [3:0]  gnt3;
  logic        rsp_valid3, rsp_ready3;
  logic [1:0]  rsp_id3;
  logic [7:0]  rsp_data3;

  int n_checks;
  int n_fail;

  logic_unit_arbiter #(.N(4), .W(8), .LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  logic_unit_arbiter #(.N(4), .W(8), .LAT(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req3),
    .op        (op3),
    .in1       (in13),
    .in2       (in23),
    .gnt       (gnt3),
    .rsp_valid (rsp_valid3),
    .rsp_ready (rsp_ready3),
    .rsp_id    (rsp_id3),
    .rsp_data  (rsp_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; req3 = '0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0; req3 = '0; op = '0; in1 = '0; in2 = '0;
    op3 = '0; in13 = '0; in23 = '0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    n_checks++;
    if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    n_checks++;
    if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rsp_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; op[2:0] = OP_AND; in1[7:0] = 8'hF0; in2[7:0] = 8'h3C;
    #1;
    n_checks++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    tick();
    req = 4'b0000;
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_busy_gnt: got %b want 0000", gnt); end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    n_checks++;
    if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    n_checks++;
    if (rsp_data !== 8'h30) begin n_fail++; $display("FAIL single_data: got %h want 30", rsp_data); end
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_accept: got %b want 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    int         who;
    do_reset();
    op  = {4{OP_PASS}};
    in1 = 32'h13121110;
    in2 = '0;
    req = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 15; c++) begin
      who     = (c / 3) % 4;
      exp_gnt = (c % 3 == 0) ? (4'b0001 << who) : 4'b0000;
      n_checks++;
      if (gnt !== exp_gnt) begin
        n_fail++; $display("FAIL rr_gnt cycle %0d: got %b want %b", c, gnt, exp_gnt);
      end
      if (c % 3 == 2) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(who) || rsp_data !== 8'(8'h10 + who)) begin
          n_fail++;
          $display("FAIL rr_rsp cycle %0d: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                   c, rsp_valid, rsp_id, rsp_data, who, 8'(8'h10 + who));
        end
      end else begin
        n_checks++;
        if (rsp_valid !== 1'b0) begin
          n_fail++; $display("FAIL rr_valid cycle %0d: got %b want 0", c, rsp_valid);
        end
      end
      tick();
    end
    req = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    op[8:6] = OP_OR; in1[23:16] = 8'h81; in2[23:16] = 8'h18;
    req = 4'b0100;
    #1;
    n_checks++;
    if (gnt !== 4'b0100) begin n_fail++; $display("FAIL bp_gnt: got %b want 0100", gnt); end
    tick();
    req = 4'b1011;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h99 || rsp_id !== 2'd2 || gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got v=%b d=%h id=%0d g=%b want v=1 d=99 id=2 g=0000",
                 c, rsp_valid, rsp_data, rsp_id, gnt);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || gnt !== 4'b0000) begin
      n_fail++; $display("FAIL bp_ready_cycle: got v=%b g=%b want v=1 g=0000", rsp_valid, gnt);
    end
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || gnt !== 4'b1000) begin
      n_fail++; $display("FAIL bp_idle: got v=%b g=%b want v=0 g=1000", rsp_valid, gnt);
    end
    req = '0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    op[5:3] = OP_XOR; in1[15:8] = 8'h3C; in2[15:8] = 8'hFF;
    req = 4'b0110;
    #1;
    n_checks++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rb_first_gnt: got %b want 0010", gnt); end
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rb_busy_gnt: got %b want 0000", gnt); end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rb_valid: got %b want 0", rsp_valid); end
    n_checks++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rb_ptr_gnt: got %b want 0010", gnt); end
    tick();
    req = '0;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL rb_rsp: got v=%b id=%0d d=%h want v=1 id=1 d=c3", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_opcodes();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hA5};
    do_reset();
    rsp_ready = 1'b1;
    in1[15:8] = 8'hA5; in2[15:8] = 8'h0F;
    for (int k = 0; k < 8; k++) begin
      op[5:3] = 3'(k);
      req = 4'b0010;
      tick();
      req = 4'b0000;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_tab[k]) begin
        n_fail++;
        $display("FAIL opcode %0d: got v=%b d=%h want v=1 d=%h", k, rsp_valid, rsp_data, exp_tab[k]);
      end
      tick();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_lat3();
    do_reset();
    rsp_ready3 = 1'b1;
    op3[2:0] = OP_XOR; in13[7:0] = 8'hA5; in23[7:0] = 8'h0F;
    req3 = 4'b0001;
    #1;
    n_checks++;
    if (gnt3 !== 4'b0001) begin n_fail++; $display("FAIL lat3_gnt: got %b want 0001", gnt3); end
    tick();
    req3 = 4'b0000;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (rsp_valid3 !== 1'b0) begin
        n_fail++; $display("FAIL lat3_early t+%0d: got %b want 0", c, rsp_valid3);
      end
      tick();
    end
    n_checks++;
    if (rsp_valid3 !== 1'b1 || rsp_data3 !== 8'hAA || rsp_id3 !== 2'd0) begin
      n_fail++;
      $display("FAIL lat3_rsp: got v=%b d=%h id=%0d want v=1 d=aa id=0", rsp_valid3, rsp_data3, rsp_id3);
    end
    tick();
    rsp_ready3 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_busy();
    test_opcodes();
    test_lat3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
